// File: rtl/soml_distance_gen.sv
// SOML distance generator: four QPSK squared distances |y - h*s_k|^2 per sample,
// computed in three registered stages that stall together under one enable.
module soml_distance_gen #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] y_re,
    input  logic signed [N-1:0] y_im,
    input  logic signed [N-1:0] h_re,
    input  logic signed [N-1:0] h_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] d0,
    output logic signed [N-1:0] d1,
    output logic signed [N-1:0] d2,
    output logic signed [N-1:0] d3,
    output logic        [3:0]   out_sat
);
    localparam int EW = N + 2;
    localparam int SW = 2 * N + 4;
    localparam int AW = 2 * N + 5;
    localparam logic [AW-1:0] D_MAX = AW'((64'd1 << (N - 1)) - 64'd1);
    // Candidate k is s = a + jb; bit k set means the component is +1.
    localparam logic [3:0] A_POS = 4'b1001;
    localparam logic [3:0] B_POS = 4'b0011;

    // Valid/ready: a beat transfers on valid && ready at either port. A single
    // enable advances or holds every stage at once, so in_ready tracks out_ready
    // combinationally whenever the output register is occupied.
    logic en;
    logic v1, v2, v3;

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    logic signed [EW-1:0] yr_x, yi_x, hr_x, hi_x;

    assign yr_x = {{2{y_re[N-1]}}, y_re};
    assign yi_x = {{2{y_im[N-1]}}, y_im};
    assign hr_x = {{2{h_re[N-1]}}, h_re};
    assign hi_x = {{2{h_im[N-1]}}, h_im};

    logic [4*N-1:0] d_all;
    logic [3:0]     sat_all;

    for (genvar k = 0; k < 4; k++) begin : gen_cand
        logic signed [EW-1:0] a_hr, a_hi, b_hr, b_hi;
        logic signed [EW-1:0] e_re_d, e_im_d, e_re_q, e_im_q;
        logic signed [SW-1:0] e_re_w, e_im_w;
        logic        [SW-1:0] sq_re_q, sq_im_q;
        logic        [AW-1:0] sum, sum_sh;
        logic        [N-1:0]  d_q;
        logic                 sat_q;

        assign a_hr = A_POS[k] ? hr_x : -hr_x;
        assign a_hi = A_POS[k] ? hi_x : -hi_x;
        assign b_hr = B_POS[k] ? hr_x : -hr_x;
        assign b_hi = B_POS[k] ? hi_x : -hi_x;

        // e = y - h*s with h*s = (a*h_re - b*h_im) + j(b*h_re + a*h_im).
        assign e_re_d = yr_x - a_hr + b_hi;
        assign e_im_d = yi_x - b_hr - a_hi;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_re_q <= '0;
                e_im_q <= '0;
            end else if (en && in_valid) begin
                e_re_q <= e_re_d;
                e_im_q <= e_im_d;
            end
        end

        assign e_re_w = {{(SW-EW){e_re_q[EW-1]}}, e_re_q};
        assign e_im_w = {{(SW-EW){e_im_q[EW-1]}}, e_im_q};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sq_re_q <= '0;
                sq_im_q <= '0;
            end else if (en && v1) begin
                sq_re_q <= $unsigned(e_re_w * e_re_w);
                sq_im_q <= $unsigned(e_im_w * e_im_w);
            end
        end

        assign sum    = {1'b0, sq_re_q} + {1'b0, sq_im_q};
        assign sum_sh = sum >> Q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q   <= '0;
                sat_q <= 1'b0;
            end else if (en && v2) begin
                if (sum_sh > D_MAX) begin
                    d_q   <= D_MAX[N-1:0];
                    sat_q <= 1'b1;
                end else begin
                    d_q   <= sum_sh[N-1:0];
                    sat_q <= 1'b0;
                end
            end
        end

        assign d_all[k*N +: N] = d_q;
        assign sat_all[k]      = sat_q;
    end

    assign d0      = d_all[0*N +: N];
    assign d1      = d_all[1*N +: N];
    assign d2      = d_all[2*N +: N];
    assign d3      = d_all[3*N +: N];
    assign out_sat = sat_all;

endmodule

// File: tb/tb_soml_distance_gen.sv
// Bench for soml_distance_gen: hand-computed vector table streamed through the
// pipeline, plus latency, stall and mid-stream reset sequences.
module tb_soml_distance_gen;
    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int W  = 4 + 4 * N;
    localparam int NV = 10;

    typedef struct packed {
        logic [N-1:0] y_re;
        logic [N-1:0] y_im;
        logic [N-1:0] h_re;
        logic [N-1:0] h_im;
        logic [N-1:0] e0;
        logic [N-1:0] e1;
        logic [N-1:0] e2;
        logic [N-1:0] e3;
        logic [3:0]   sat;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y_re, y_im, h_re, h_im;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d0, d1, d2, d3;
    logic [3:0]   out_sat;

    vec_t         vecs [NV];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] cur_exp;
    int           vec_cnt;
    int           err_cnt;

    soml_distance_gen #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .h_re      (h_re),
        .h_im      (h_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_sat   (out_sat)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int yr, int yi, int hr, int hi,
                                int e0, int e1, int e2, int e3, logic [3:0] sat);
        vec_t v;
        v.y_re = 16'(yr);
        v.y_im = 16'(yi);
        v.h_re = 16'(hr);
        v.h_im = 16'(hi);
        v.e0   = 16'(e0);
        v.e1   = 16'(e1);
        v.e2   = 16'(e2);
        v.e3   = 16'(e3);
        v.sat  = sat;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int i);
        in_valid = 1'b1;
        y_re     = vecs[i].y_re;
        y_im     = vecs[i].y_im;
        h_re     = vecs[i].h_re;
        h_im     = vecs[i].h_im;
        cur_exp  = {vecs[i].sat, vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0};
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        y_re     = 16'h5A5A;
        y_im     = 16'hA5A5;
        h_re     = 16'h1234;
        h_im     = 16'h4321;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", W'(exp_q.size()), W'(0));
        next_cycle();
    endtask

    // scoreboard: pop on output transfer, push on input transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_out: got %h, expected no output", {out_sat, d3, d2, d1, d0});
                end else begin
                    check("out_data", {out_sat, d3, d2, d1, d0}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        int p;
        vec_cnt = 0;
        err_cnt = 0;
        cur_exp = '0;

        vecs[0] = mk(256, 256, 256, 0,          0, 1024, 2048, 1024, 4'h0);
        vecs[1] = mk(0, 0, 0, 256,              512, 512, 512, 512, 4'h0);
        vecs[2] = mk(32767, 32767, -32768, -32768, 32767, 32767, 32767, 32767, 4'hF);
        vecs[3] = mk(100, -50, 128, 64,         233, 383, 183, 33, 4'h0);
        vecs[4] = mk(2896, 40, 0, 0,            32767, 32767, 32767, 32767, 4'h0);
        vecs[5] = mk(2896, 48, 0, 0,            32767, 32767, 32767, 32767, 4'hF);
        vecs[6] = mk(2048, 2048, 2048, 0,       0, 32767, 32767, 32767, 4'b1110);
        vecs[7] = mk(17, 0, 0, 0,               1, 1, 1, 1, 4'h0);
        vecs[8] = mk(-16, -16, 0, 0,            2, 2, 2, 2, 4'h0);
        vecs[9] = mk(15, 0, 0, 0,               0, 0, 0, 0, 4'h0);

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_outputs", {out_sat, d3, d2, d1, d0}, W'(0));
        next_cycle();

        // single sample: out_valid exactly three cycles after acceptance
        drive_vec(0);
        next_cycle();
        drive_idle();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", c), W'(out_valid), W'(c == 3));
            next_cycle();
        end
        drain();

        // whole table back-to-back at full rate
        for (int c = 0; c < NV + 4; c++) begin
            if (c < NV) drive_vec(c);
            else drive_idle();
            @(negedge clk);
            check("stream_in_ready", W'(in_ready), W'(1));
            if (c >= 3) check($sformatf("stream_out_valid_c%0d", c), W'(out_valid), W'(c < NV + 3));
            next_cycle();
        end
        drain();

        // stall with the pipeline full: five cycles of out_ready low
        p = 0;
        for (int c = 0; c < 60 && (p < NV || exp_q.size() != 0); c++) begin
            out_ready = !(c >= 5 && c < 10);
            if (p < NV) drive_vec(p);
            else drive_idle();
            @(negedge clk);
            if (c >= 5 && c < 10) begin
                check("stall_in_ready", W'(in_ready), W'(0));
                check("stall_out_valid", W'(out_valid), W'(1));
                if (exp_q.size() != 0) check("stall_hold", {out_sat, d3, d2, d1, d0}, exp_q[0]);
                else check("stall_queue", W'(exp_q.size()), W'(3));
            end
            if (in_valid && in_ready) p++;
            next_cycle();
        end
        out_ready = 1'b1;
        drive_idle();
        check("stall_all_sent", W'(p), W'(NV));
        drain();

        // reset with two samples in flight, the older one held at the output
        out_ready = 1'b0;
        drive_vec(3);
        next_cycle();
        drive_vec(7);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        check("pre_reset_valid", W'(out_valid), W'(1));
        check("pre_reset_data", {out_sat, d3, d2, d1, d0}, exp_q[0]);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", W'(out_valid), W'(0));
        check("async_reset_outputs", {out_sat, d3, d2, d1, d0}, W'(0));
        check("async_reset_in_ready", W'(in_ready), W'(1));
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_valid", W'(out_valid), W'(0));
            check("post_reset_outputs", {out_sat, d3, d2, d1, d0}, W'(0));
        end
        next_cycle();

        // recovery after reset
        drive_vec(6);
        next_cycle();
        drive_idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
